// File: rtl/i2c_seq_pkg.sv
// Shared types and defaults for the I2C command sequencer:
// FSM state encoding, command/response records and shift-register codes.
package i2c_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP,
        GAP
    } state_t;

    // One queued host command.
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    // One completed-command response.
    typedef struct packed {
        logic       rw;
        logic       err;
        logic [7:0] data;
    } rsp_t;

    localparam logic [2:0] SR_LOAD_DEFAULT = 3'b011;
    localparam logic [2:0] SR_HOLD_DEFAULT = 3'b000;

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Host-side command/response handshake bundle for the I2C command sequencer.
// The host drives through the master modport; the sequencer sits on slave.
interface i2c_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_rw;
    logic       rsp_err;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rw, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rw, rsp_err, rsp_data
    );

endinterface

// File: rtl/seq_sync_fifo.sv
// Same-clock FIFO with full/empty flags.
// With BYPASS set, a push into an empty FIFO is visible on dout in the same
// cycle and may be popped immediately, so push and pop both take effect.
module seq_sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || (BYPASS && push));
    assign dout    = (BYPASS && empty) ? din : mem[rd_ptr];

    // Storage write port.
    // NOTE: the storage array has no reset; count/pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C read/write commands and issues them one at a time to the
// I2C top: loads the shift register, raises Master_en, waits for a rising
// done (or times out) and returns one response per command.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 1023,
    parameter logic [2:0] SR_LOAD = SR_LOAD_DEFAULT,
    parameter logic [2:0] SR_HOLD = SR_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_cmd_sequencer_if.slave   host,
    output logic                 i2c_master_en,
    output logic                 i2c_r_w_en,
    output logic [6:0]           i2c_mem_addr,
    output logic [7:0]           i2c_sr_data,
    output logic [2:0]           i2c_sr_sel,
    input  logic                 i2c_done,
    input  logic [7:0]           i2c_data_out,
    output logic                 busy
);

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_C = TW'(TIMEOUT);

    state_t        state;
    logic [TW-1:0] cnt;
    logic          done_q;
    logic          done_edge;
    rsp_t          rsp_q;

    cmd_t cmd_in;
    cmd_t cmd_head;
    logic cmd_push;
    logic cmd_pop;
    logic cmd_avail;
    logic cmd_full;
    logic cmd_empty;

    rsp_t rsp_head;
    logic rsp_push;
    logic rsp_pop;
    logic rsp_full;
    logic rsp_empty;

    assign cmd_in         = '{rw: host.cmd_rw, addr: host.cmd_addr, data: host.cmd_data};
    assign host.cmd_ready = !cmd_full;
    assign cmd_push       = host.cmd_valid && host.cmd_ready;
    // A command arriving into an empty queue is taken by IDLE in the same cycle.
    assign cmd_avail      = !cmd_empty || cmd_push;
    assign cmd_pop        = (state == IDLE) && cmd_avail;

    assign rsp_push       = (state == RESP) && !rsp_full;
    assign rsp_pop        = host.rsp_valid && host.rsp_ready;
    assign host.rsp_valid = !rsp_empty;
    assign host.rsp_rw    = rsp_head.rw;
    assign host.rsp_err   = rsp_head.err;
    assign host.rsp_data  = rsp_head.data;

    assign done_edge = i2c_done & ~done_q;
    assign busy      = (state != IDLE) || !cmd_empty;

    seq_sync_fifo #(
        .WIDTH  ($bits(cmd_t)),
        .DEPTH  (DEPTH),
        .BYPASS (1'b1)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_push),
        .din   (cmd_in),
        .pop   (cmd_pop),
        .dout  (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    seq_sync_fifo #(
        .WIDTH  ($bits(rsp_t)),
        .DEPTH  (DEPTH),
        .BYPASS (1'b0)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rsp_push),
        .din   (rsp_q),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    // Command sequencing FSM with registered I2C-side outputs.
    // NOTE: non-blocking assignments keep every register update based on pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            i2c_master_en <= 1'b0;
            i2c_r_w_en    <= 1'b0;
            i2c_mem_addr  <= '0;
            i2c_sr_data   <= '0;
            i2c_sr_sel    <= SR_HOLD;
            cnt           <= '0;
            done_q        <= 1'b0;
            rsp_q         <= '0;
        end else begin
            done_q <= i2c_done;
            case (state)
                IDLE: begin
                    if (cmd_avail) begin
                        i2c_r_w_en   <= cmd_head.rw;
                        i2c_mem_addr <= cmd_head.addr;
                        i2c_sr_data  <= cmd_head.data;
                        i2c_sr_sel   <= SR_LOAD;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    i2c_sr_sel <= SR_HOLD;
                    state      <= START;
                end
                START: begin
                    i2c_master_en <= 1'b1;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    // done edge has priority over a coincident timeout
                    if (done_edge) begin
                        rsp_q         <= '{rw: i2c_r_w_en, err: 1'b0,
                                           data: i2c_r_w_en ? i2c_data_out : 8'h00};
                        i2c_master_en <= 1'b0;
                        state         <= RESP;
                    end else if (cnt == TIMEOUT_C) begin
                        rsp_q         <= '{rw: i2c_r_w_en, err: 1'b1, data: 8'h00};
                        i2c_master_en <= 1'b0;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                RESP: begin
                    i2c_master_en <= 1'b0;
                    if (!rsp_full) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer: cycle-exact vector table for a
// single write and a single read, then hand-written back-to-back, timeout,
// backpressure, mid-operation reset and stale-done sequences.
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    localparam int TIMEOUT  = 1023;
    localparam int AUTO_LAT = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    i2c_cmd_sequencer_if bus ();

    logic       i2c_master_en;
    logic       i2c_r_w_en;
    logic [6:0] i2c_mem_addr;
    logic [7:0] i2c_sr_data;
    logic [2:0] i2c_sr_sel;
    logic       i2c_done;
    logic [7:0] i2c_data_out;
    logic       busy;

    logic       man_done  = 1'b0;
    logic [7:0] man_dout  = 8'h00;
    logic       auto_en   = 1'b0;
    logic       auto_done = 1'b0;
    logic [7:0] auto_dout = 8'h00;

    assign i2c_done     = auto_en ? auto_done : man_done;
    assign i2c_data_out = auto_en ? auto_dout : man_dout;

    i2c_cmd_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host          (bus.slave),
        .i2c_master_en (i2c_master_en),
        .i2c_r_w_en    (i2c_r_w_en),
        .i2c_mem_addr  (i2c_mem_addr),
        .i2c_sr_data   (i2c_sr_data),
        .i2c_sr_sel    (i2c_sr_sel),
        .i2c_done      (i2c_done),
        .i2c_data_out  (i2c_data_out),
        .busy          (busy)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    rsp_t exp_q[$];
    logic sb_en = 1'b0;
    int   rises = 0;

    typedef struct {
        int         ncyc;
        logic       cv, rw;
        logic [6:0] addr;
        logic [7:0] data;
        logic       done;
        logic [7:0] dout;
        logic       rr;
        logic       e_me, e_rwen;
        logic [6:0] e_addr;
        logic [7:0] e_srd;
        logic [2:0] e_sel;
        logic       e_rv, e_rrw, e_rerr;
        logic [7:0] e_rd;
        logic       e_crdy, e_busy;
    } vec_t;

    vec_t vecs[15];

    // Read data the modelled I2C slave returns for an address.
    function automatic logic [7:0] rd_val(input logic [6:0] a);
        return {1'b0, a} ^ 8'hA6;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d);
        int budget;
        budget = 200;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        while (!bus.cmd_ready && budget > 0) begin
            step(1);
            budget--;
        end
        check("push_accepted", bus.cmd_ready, 1'b1);
        step(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_me_high(input string name);
        int budget;
        budget = 20;
        while (!i2c_master_en && budget > 0) begin
            step(1);
            budget--;
        end
        check(name, i2c_master_en, 1'b1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        while ((exp_q.size() != 0 || busy || bus.rsp_valid) && budget > 0) begin
            step(1);
            budget--;
        end
        check(name, (budget > 0), 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".master_en"}, i2c_master_en, 1'b0);
        check({tag, ".r_w_en"},    i2c_r_w_en,    1'b0);
        check({tag, ".mem_addr"},  i2c_mem_addr,  7'h00);
        check({tag, ".sr_data"},   i2c_sr_data,   8'h00);
        check({tag, ".sr_sel"},    i2c_sr_sel,    SR_HOLD_DEFAULT);
        check({tag, ".rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, ".cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, ".busy"},      busy,          1'b0);
    endtask

    // Response scoreboard and master_en rise counter, sampled mid-cycle.
    initial begin
        rsp_t e;
        logic me_prev;
        me_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_en && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got rw=%0b err=%0b data=%02h, expected no response",
                             bus.rsp_rw, bus.rsp_err, bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rw",   bus.rsp_rw,   e.rw);
                    check("rsp_err",  bus.rsp_err,  e.err);
                    check("rsp_data", bus.rsp_data, e.data);
                end
            end
            if (i2c_master_en && !me_prev) rises++;
            me_prev = i2c_master_en;
        end
    end

    // Modelled I2C top: pulses done AUTO_LAT cycles into each master_en window.
    initial begin
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_en) begin
                k = 0;
                auto_done = 1'b0;
            end else if (auto_done) begin
                auto_done = 1'b0;
            end else if (i2c_master_en) begin
                k++;
                if (k == AUTO_LAT) begin
                    auto_dout = rd_val(i2c_mem_addr);
                    auto_done = 1'b1;
                    k = 0;
                end
            end else begin
                k = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        int hi;
        int me_hi;
        int unstable;

        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        //        ncyc cv rw addr   data   done dout  rr | me rwen addr   srd    sel              rv rrw rerr rd    crdy busy
        vecs[0]  = '{1,  1, 0, 7'h15, 8'hA5, 0, 8'h00, 0,  0, 0, 7'h15, 8'hA5, SR_LOAD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[1]  = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h00, 0,  0, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[2]  = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h00, 0,  1, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[3]  = '{10, 0, 0, 7'h00, 8'h00, 0, 8'h00, 0,  1, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[4]  = '{1,  0, 0, 7'h00, 8'h00, 1, 8'h00, 0,  0, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[5]  = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h00, 0,  0, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 1, 0, 0, 8'h00, 1, 1};
        vecs[6]  = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h00, 0,  0, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 1, 0, 0, 8'h00, 1, 0};
        vecs[7]  = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h00, 1,  0, 0, 7'h15, 8'hA5, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 0};
        vecs[8]  = '{1,  1, 1, 7'h15, 8'h00, 0, 8'h3C, 1,  0, 1, 7'h15, 8'h00, SR_LOAD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[9]  = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h3C, 1,  0, 1, 7'h15, 8'h00, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[10] = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h3C, 1,  1, 1, 7'h15, 8'h00, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[11] = '{4,  0, 0, 7'h00, 8'h00, 0, 8'h3C, 1,  1, 1, 7'h15, 8'h00, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[12] = '{1,  0, 0, 7'h00, 8'h00, 1, 8'h3C, 1,  0, 1, 7'h15, 8'h00, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 1};
        vecs[13] = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h99, 1,  0, 1, 7'h15, 8'h00, SR_HOLD_DEFAULT, 1, 1, 0, 8'h3C, 1, 1};
        vecs[14] = '{1,  0, 0, 7'h00, 8'h00, 0, 8'h99, 1,  0, 1, 7'h15, 8'h00, SR_HOLD_DEFAULT, 0, 0, 0, 8'h00, 1, 0};

        // Reset state
        step(3);
        check_reset_state("reset");
        reset = 1'b0;
        step(1);

        // Single write then single read, cycle by cycle
        for (int i = 0; i < 15; i++) begin
            bus.cmd_valid = vecs[i].cv;
            bus.cmd_rw    = vecs[i].rw;
            bus.cmd_addr  = vecs[i].addr;
            bus.cmd_data  = vecs[i].data;
            man_done      = vecs[i].done;
            man_dout      = vecs[i].dout;
            bus.rsp_ready = vecs[i].rr;
            step(vecs[i].ncyc);
            check($sformatf("vec%0d.master_en", i), i2c_master_en, vecs[i].e_me);
            check($sformatf("vec%0d.r_w_en", i),    i2c_r_w_en,    vecs[i].e_rwen);
            check($sformatf("vec%0d.mem_addr", i),  i2c_mem_addr,  vecs[i].e_addr);
            check($sformatf("vec%0d.sr_data", i),   i2c_sr_data,   vecs[i].e_srd);
            check($sformatf("vec%0d.sr_sel", i),    i2c_sr_sel,    vecs[i].e_sel);
            check($sformatf("vec%0d.rsp_valid", i), bus.rsp_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) begin
                check($sformatf("vec%0d.rsp_rw", i),   bus.rsp_rw,   vecs[i].e_rrw);
                check($sformatf("vec%0d.rsp_err", i),  bus.rsp_err,  vecs[i].e_rerr);
                check($sformatf("vec%0d.rsp_data", i), bus.rsp_data, vecs[i].e_rd);
            end
            check($sformatf("vec%0d.cmd_ready", i), bus.cmd_ready, vecs[i].e_crdy);
            check($sformatf("vec%0d.busy", i),      busy,          vecs[i].e_busy);
        end

        // Back-to-back: five commands, four of them queue behind the first
        sb_en = 1'b1;
        auto_en = 1'b1;
        bus.rsp_ready = 1'b1;
        rises = 0;
        exp_q.push_back('{rw: 1'b0, err: 1'b0, data: 8'h00});
        exp_q.push_back('{rw: 1'b1, err: 1'b0, data: rd_val(7'h02)});
        exp_q.push_back('{rw: 1'b1, err: 1'b0, data: rd_val(7'h03)});
        exp_q.push_back('{rw: 1'b0, err: 1'b0, data: 8'h00});
        exp_q.push_back('{rw: 1'b1, err: 1'b0, data: rd_val(7'h05)});
        push_cmd(1'b0, 7'h01, 8'h11);
        push_cmd(1'b1, 7'h02, 8'h00);
        push_cmd(1'b1, 7'h03, 8'h00);
        push_cmd(1'b0, 7'h04, 8'h44);
        push_cmd(1'b1, 7'h05, 8'h00);
        check("b2b_cmd_fifo_full", bus.cmd_ready, 1'b0);
        wait_idle("b2b_drain", 500);
        check("b2b_master_en_windows", rises, 5);

        // Timeout: done never arrives, then a late pulse is ignored
        auto_en = 1'b0;
        man_done = 1'b0;
        exp_q.push_back('{rw: 1'b1, err: 1'b1, data: 8'h00});
        push_cmd(1'b1, 7'h22, 8'h00);
        wait_me_high("timeout_me_rise");
        hi = 0;
        while (i2c_master_en && hi < TIMEOUT + 20) begin
            hi++;
            step(1);
        end
        check("timeout_me_high_cycles", hi, TIMEOUT + 1);
        man_done = 1'b1;
        step(1);
        man_done = 1'b0;
        wait_idle("timeout_drain", 50);
        step(5);
        check("timeout_late_done_rsp_valid", bus.rsp_valid, 1'b0);
        check("timeout_late_done_busy", busy, 1'b0);

        // Backpressure: response FIFO fills, FSM stalls in RESP
        bus.rsp_ready = 1'b0;
        auto_en = 1'b1;
        rises = 0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{rw: 1'b1, err: 1'b0, data: rd_val(7'(8'h60 + i))});
            push_cmd(1'b1, 7'(8'h60 + i), 8'h00);
        end
        step(120);
        check("bp_rises", rises, 5);
        check("bp_busy", busy, 1'b1);
        check("bp_rsp_valid", bus.rsp_valid, 1'b1);
        check("bp_cmd_ready", bus.cmd_ready, 1'b1);
        me_hi = 0;
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            if (i2c_master_en) me_hi++;
            if (bus.rsp_data !== exp_q[0].data || bus.rsp_rw !== exp_q[0].rw) unstable++;
            step(1);
        end
        check("bp_stall_master_en_low", me_hi, 0);
        check("bp_rsp_hold_stable", unstable, 0);
        bus.rsp_ready = 1'b1;
        wait_idle("bp_drain", 300);
        check("bp_no_extra_windows", rises, 5);

        // Reset mid-read with a second command queued
        auto_en = 1'b0;
        sb_en = 1'b0;
        man_done = 1'b0;
        push_cmd(1'b1, 7'h40, 8'h00);
        push_cmd(1'b0, 7'h41, 8'h77);
        wait_me_high("rst_me_rise");
        step(3);
        reset = 1'b1;
        step(1);
        check_reset_state("rst_mid");
        reset = 1'b0;
        exp_q.delete();
        step(3);
        check("rst_queue_discarded_busy", busy, 1'b0);
        check("rst_no_rsp", bus.rsp_valid, 1'b0);

        // Stale done level held into WAIT must not complete the command
        sb_en = 1'b1;
        man_done = 1'b1;
        man_dout = 8'hEE;
        exp_q.push_back('{rw: 1'b1, err: 1'b0, data: 8'h6E});
        push_cmd(1'b1, 7'h33, 8'h00);
        wait_me_high("stale_me_rise");
        step(20);
        check("stale_master_en_held", i2c_master_en, 1'b1);
        check("stale_no_rsp", bus.rsp_valid, 1'b0);
        check("stale_pending", exp_q.size(), 1);
        man_done = 1'b0;
        step(2);
        man_dout = 8'h6E;
        man_done = 1'b1;
        step(1);
        man_done = 1'b0;
        wait_idle("stale_drain", 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
